tlul_sram_adapter: RTL and testbench

TL-UL device stage that terminates the TileLink-UL host port produced by the AHB-to-TL-UL bridge and maps it onto a single-port synchronous SRAM with 1-cycle read latency. It accepts A-channel Get/PutFullData/PutPartialData requests and checks them for legality. It drives the SRAM macro and returns AccessAck/AccessAckData responses on the D channel through a response FIFO that absorbs `d_ready` backpressure.

---
 rtl/Default_pkg.sv | 10 +
 rtl/TileLinkUL_pkg.sv | 57 +++++
 rtl/tlul_rsp_fifo.sv | 56 +++++
 rtl/tlul_sram_adapter.sv | 133 +++++++++++++
 tb/tb_tlul_sram_adapter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/Default_pkg.sv
// Bus-wide width constants shared by every TL-UL block in this slice.
package Default_pkg;

  localparam int TL_AW   = 32;
  localparam int TL_DW   = 32;
  localparam int TL_DBW  = TL_DW / 8;
  localparam int TL_SZW  = 2;
  localparam int TL_SRCW = 8;

endpackage

// File: rtl/TileLinkUL_pkg.sv
// TileLink-UL opcodes, channel structs and the response-entry layout.
package TileLinkUL_pkg;

  import Default_pkg::*;

  // A-channel opcodes
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;

  // D-channel opcodes
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

  // Host to device: A channel plus D-channel ready
  typedef struct packed {
    logic                a_valid;
    logic [2:0]          a_opcode;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_SRCW-1:0]  a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic                d_ready;
  } tl_m2s_t;

  // Device to host: D channel plus A-channel ready
  typedef struct packed {
    logic                d_valid;
    logic [2:0]          d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_SRCW-1:0]  d_source;
    logic                d_sink;
    logic [TL_DW-1:0]    d_data;
    logic                d_error;
    logic                a_ready;
  } tl_s2m_t;

  // One queued response, everything the D channel needs to replay it
  typedef struct packed {
    logic [2:0]          opcode;
    logic [TL_SZW-1:0]   size;
    logic [TL_SRCW-1:0]  source;
    logic                error;
    logic [TL_DW-1:0]    data;
  } tl_rsp_entry_t;

  // Byte mask a PutFullData must carry for its size and byte offset
  function automatic logic [TL_DBW-1:0] full_mask(input logic [TL_SZW-1:0] size,
                                                   input logic [1:0]        lo);
    if (size == TL_SZW'(0)) return TL_DBW'(1) << lo;
    if (size == TL_SZW'(1)) return TL_DBW'(3) << lo;
    return '1;
  endfunction

endpackage

// File: rtl/tlul_rsp_fifo.sv
// Generic synchronous FIFO with occupancy count; any depth >= 2.
module tlul_rsp_fifo #(
  parameter int Width = 8,
  parameter int Depth = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  logic [Width-1:0]           wdata,
  input  logic                       pop,
  output logic [Width-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full  = (count == CntW'(Depth));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (rd_en) rd_ptr <= next_ptr(rd_ptr);
      if (wr_en && !rd_en)      count <= count + CntW'(1);
      else if (rd_en && !wr_en) count <= count - CntW'(1);
    end
  end

  // Storage array
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; count gates every read, so stale contents are never visible.
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tlul_sram_adapter.sv
// TL-UL device terminating the bridge host port onto a 1-cycle-latency SRAM.
// Requests are checked, legal ones strobe the SRAM in the handshake cycle,
// and responses return in order through a credit-protected response FIFO.
module tlul_sram_adapter
  import Default_pkg::*;
  import TileLinkUL_pkg::*;
#(
  parameter int SramAw   = 10,
  parameter int RspDepth = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tl_m2s_t           tl_i,
  output tl_s2m_t           tl_o,
  output logic              req_o,
  output logic              we_o,
  output logic [SramAw-1:0] addr_o,
  output logic [TL_DW-1:0]  wdata_o,
  output logic [TL_DW-1:0]  wmask_o,
  input  logic [TL_DW-1:0]  rdata_i
);

  localparam int CntW   = $clog2(RspDepth + 1);
  localparam int EntryW = $bits(tl_rsp_entry_t);

  // Stage 1: request accepted last cycle, waiting for its SRAM read data
  logic               s1_valid;
  logic               s1_is_get;
  logic               s1_error;
  logic [TL_SZW-1:0]  s1_size;
  logic [TL_SRCW-1:0] s1_source;

  logic               is_get, is_put;
  logic               err_opcode, err_size, err_align, err_range, err_mask, a_error;
  logic               a_ready, handshake;
  logic               d_valid, pop;
  logic [CntW-1:0]    fifo_count;
  logic               fifo_full, fifo_empty;
  tl_rsp_entry_t      push_entry, head_entry;

  // Decode the A beat and evaluate every legality rule
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    is_get     = (tl_i.a_opcode == Get);
    is_put     = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    err_opcode = !(is_get || is_put);
    err_size   = (tl_i.a_size > TL_SZW'(2));
    err_align  = 1'b0;
    if (tl_i.a_size == TL_SZW'(1))      err_align = tl_i.a_address[0];
    else if (tl_i.a_size != TL_SZW'(0)) err_align = |tl_i.a_address[1:0];
    err_range  = |tl_i.a_address[TL_AW-1:SramAw+2];
    err_mask   = (tl_i.a_opcode == PutFullData) &&
                 (tl_i.a_mask != full_mask(tl_i.a_size, tl_i.a_address[1:0]));
    a_error    = err_opcode || err_size || err_align || err_range || err_mask;
  end

  // Credit rule: every accepted beat already owns a FIFO slot, so d_ready never reaches a_ready
  assign a_ready   = rst_ni &&
                     (({1'b0, fifo_count} + (CntW+1)'(s1_valid)) < (CntW+1)'(RspDepth));
  assign handshake = tl_i.a_valid && a_ready;

  // SRAM strobe is combinational in the handshake cycle; errored beats never touch the macro
  assign req_o   = handshake && !a_error;
  assign we_o    = req_o && is_put;
  assign addr_o  = tl_i.a_address[SramAw+1:2];
  assign wdata_o = tl_i.a_data;

  // Expand byte enables into a bit mask
  always_comb begin
    wmask_o = '0;
    for (int i = 0; i < TL_DBW; i++) wmask_o[8*i +: 8] = {8{tl_i.a_mask[i]}};
  end

  // Stage 1 register, loaded on every handshake
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= handshake;
      if (handshake) begin
        s1_is_get <= is_get;
        s1_error  <= a_error;
        s1_size   <= tl_i.a_size;
        s1_source <= tl_i.a_source;
      end
    end
  end

  // Response built from stage 1; rdata_i is only trusted right after a legal read
  always_comb begin
    push_entry        = '0;
    push_entry.opcode = s1_is_get ? AccessAckData : AccessAck;
    push_entry.size   = s1_size;
    push_entry.source = s1_source;
    push_entry.error  = s1_error;
    push_entry.data   = (s1_is_get && !s1_error) ? rdata_i : '0;
  end

  tlul_rsp_fifo #(
    .Width (EntryW),
    .Depth (RspDepth)
  ) u_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (s1_valid),
    .wdata  (push_entry),
    .pop    (pop),
    .rdata  (head_entry),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign d_valid = rst_ni && !fifo_empty;
  assign pop     = d_valid && tl_i.d_ready;

  // D channel replays the FIFO head, so it stays stable under backpressure
  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = a_ready;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = head_entry.opcode;
    tl_o.d_size   = head_entry.size;
    tl_o.d_source = head_entry.source;
    tl_o.d_error  = head_entry.error;
    tl_o.d_data   = head_entry.data;
  end

  // The credit rule guarantees stage 1 never pushes into a full FIFO
  a_push_has_room : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     s1_valid |-> (!fifo_full || pop));

endmodule

// File: tb/tb_tlul_sram_adapter.sv
// Self-checking bench: SRAM behavioural model, scoreboard with its own memory
// image, directed scenarios followed by randomized traffic and d_ready.
module tb_tlul_sram_adapter;

  import Default_pkg::*;
  import TileLinkUL_pkg::*;

  localparam int SramAw   = 10;
  localparam int RspDepth = 3;
  localparam int Words    = 1 << SramAw;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  tl_m2s_t           tl_i;
  tl_s2m_t           tl_o;
  logic              req_o, we_o;
  logic [SramAw-1:0] addr_o;
  logic [TL_DW-1:0]  wdata_o, wmask_o, rdata_i;

  tlul_sram_adapter #(
    .SramAw   (SramAw),
    .RspDepth (RspDepth)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .tl_i    (tl_i),
    .tl_o    (tl_o),
    .req_o   (req_o),
    .we_o    (we_o),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .wmask_o (wmask_o),
    .rdata_i (rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          opcode;
    int          size;
    int          source;
    bit          error;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          src_log[$];
  logic [31:0] sram_mem [Words];
  logic [31:0] ref_mem  [Words];
  int          n_vec = 0, n_err = 0;
  int          hs_cnt = 0, pop_cnt = 0, derr_cnt = 0, cyc = 0;
  bit          rand_dr = 0, ref_init = 0;
  logic [31:0] last_d_data = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // SRAM macro model: 1-cycle read latency, garbage on rdata_i when not reading
  always @(posedge clk_i) begin
    if (cyc == 0) foreach (sram_mem[i]) sram_mem[i] = '0;
    rdata_i <= (req_o && !we_o) ? sram_mem[addr_o] : $urandom();
    if (req_o && we_o) sram_mem[addr_o] = (sram_mem[addr_o] & ~wmask_o) | (wdata_o & wmask_o);
    cyc <= cyc + 1;
  end

  // Reference model: judge the accepted beat from the protocol rules
  task automatic model_accept();
    int unsigned addr = tl_i.a_address;
    int          op   = int'(tl_i.a_opcode);
    int          sz   = int'(tl_i.a_size);
    int unsigned span = 1 << sz;
    int unsigned full = ((1 << span) - 1) << (addr % 4);
    int          idx  = int'((addr / 4) % Words);
    bit          legal_op = (op == 4) || (op == 0) || (op == 1);
    bit          err;
    logic [31:0] bitmask = '0;
    exp_t        e;
    err = !legal_op || (sz > 2) || ((addr % span) != 0) || ((addr >> (SramAw + 2)) != 0) ||
          ((op == 0) && (int'(tl_i.a_mask) != int'(full & 4'hF)));
    for (int b = 0; b < 4; b++) if (tl_i.a_mask[b]) bitmask |= 32'hFF << (8 * b);
    hs_cnt++;
    check("a_req", req_o, !err);
    if (!err) begin
      check("a_we", we_o, (op != 4));
      check("a_addr", addr_o, idx);
      check("a_wmask", wmask_o, bitmask);
      check("a_wdata", wdata_o, tl_i.a_data);
      if (op != 4) ref_mem[idx] = (ref_mem[idx] & ~bitmask) | (tl_i.a_data & bitmask);
    end
    e.opcode = (op == 4) ? 1 : 0;
    e.size   = sz;
    e.source = int'(tl_i.a_source);
    e.error  = err;
    e.data   = (!err && op == 4) ? ref_mem[idx] : 32'h0;
    exp_q.push_back(e);
  endtask

  // Scoreboard: compare the popped D beat with the oldest expectation
  task automatic model_retire();
    exp_t e;
    pop_cnt++;
    last_d_data = tl_o.d_data;
    src_log.push_back(int'(tl_o.d_source));
    if (tl_o.d_error) derr_cnt++;
    if (exp_q.size() == 0) begin
      check("d_spurious", tl_o.d_valid, 1'b0);
    end else begin
      e = exp_q.pop_front();
      check("d_opcode", tl_o.d_opcode, e.opcode);
      check("d_size",   tl_o.d_size,   e.size);
      check("d_source", tl_o.d_source, e.source);
      check("d_error",  tl_o.d_error,  e.error);
      check("d_data",   tl_o.d_data,   e.data);
      check("d_param",  tl_o.d_param,  3'd0);
      check("d_sink",   tl_o.d_sink,   1'b0);
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge
  always @(negedge clk_i) begin
    if (!ref_init) begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
      ref_init = 1;
    end
    if (!rst_ni) begin
      check("rst_a_ready", tl_o.a_ready, 1'b0);
      check("rst_d_valid", tl_o.d_valid, 1'b0);
      check("rst_req",     req_o,        1'b0);
      check("rst_we",      we_o,         1'b0);
      exp_q.delete();
    end else begin
      if (tl_i.a_valid && tl_o.a_ready) model_accept();
      else check("idle_req", req_o, 1'b0);
      if (tl_o.d_valid && tl_i.d_ready) model_retire();
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rand_dr) tl_i.d_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] sz,
                      input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    bit accepted = 0;
    int n = 0;
    tl_i.a_opcode  = op;
    tl_i.a_address = addr;
    tl_i.a_size    = sz;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
    tl_i.a_source  = src;
    tl_i.a_valid   = 1'b1;
    while (!accepted && n < 200) begin
      @(negedge clk_i);
      accepted = tl_o.a_ready;
      tick();
      n++;
    end
    if (!accepted) check("a_timeout", accepted, 1'b1);
    tl_i.a_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || tl_o.d_valid) && n < 1000) begin
      tick();
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic get_fields(input logic [31:0] addr, input logic [7:0] src);
    tl_i.a_opcode  = Get;
    tl_i.a_address = addr;
    tl_i.a_size    = 2'd2;
    tl_i.a_mask    = 4'hF;
    tl_i.a_source  = src;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d vectors", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start, n, first_hs, last_hs, first_dv, p0, d0;
    logic [2:0]  op;
    logic [1:0]  sz;
    logic [3:0]  mask;
    logic [31:0] addr;

    tl_i = '0;
    tl_i.d_ready = 1'b1;
    rst_ni = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;

    // Write then read back a full word
    send(PutFullData, 32'h10, 2'd2, 4'hF, 32'hDEADBEEF, 8'd0);
    send(Get,         32'h10, 2'd2, 4'hF, 32'h0,        8'd1);
    wait_drain();
    check("t1_rdata", last_d_data, 32'hDEADBEEF);

    // Partial byte write merges into an existing word
    send(PutFullData,    32'h10, 2'd2, 4'hF, 32'h11223344, 8'd2);
    send(PutPartialData, 32'h11, 2'd0, 4'h2, 32'h0000AB00, 8'd3);
    send(Get,            32'h10, 2'd2, 4'hF, 32'h0,        8'd4);
    wait_drain();
    check("t2_rdata", last_d_data, 32'h1122AB44);

    // Illegal requests: misaligned, bad opcode, out of range
    d0 = derr_cnt;
    send(Get,  32'h2,             2'd2, 4'hF, 32'h0, 8'd5);
    send(3'd3, 32'h20,            2'd2, 4'hF, 32'h0, 8'd6);
    send(Get,  32'(4 << SramAw),  2'd2, 4'hF, 32'h0, 8'd7);
    wait_drain();
    check("t3_errors", derr_cnt - d0, 3);

    // Backpressure: only RspDepth beats accepted while d_ready is low
    tl_i.d_ready = 1'b0;
    start = hs_cnt;
    src_log.delete();
    get_fields(32'h20, 8'd0);
    tl_i.a_valid = 1'b1;
    repeat (8) begin
      @(negedge clk_i);
      tick();
      tl_i.a_source = 8'(hs_cnt - start);
    end
    check("t4_hs", hs_cnt - start, RspDepth);
    check("t4_a_ready", tl_o.a_ready, 1'b0);
    tl_i.d_ready = 1'b1;
    n = 0;
    while (hs_cnt - start < 4 && n < 50) begin
      @(negedge clk_i);
      tick();
      tl_i.a_source = 8'(hs_cnt - start);
      n++;
    end
    tl_i.a_valid = 1'b0;
    check("t4_hs_total", hs_cnt - start, 4);
    wait_drain();
    check("t4_nrsp", src_log.size(), 4);
    for (int i = 0; i < 4 && i < src_log.size(); i++) check("t4_order", src_log[i], i);

    // Streaming: one Get per cycle, first response two cycles after first handshake
    tl_i.d_ready = 1'b1;
    start = hs_cnt;
    first_hs = -1;
    last_hs  = -1;
    first_dv = -1;
    n = 0;
    get_fields(32'($urandom_range(0, 63) * 4), 8'd0);
    tl_i.a_valid = 1'b1;
    while ((hs_cnt - start < 16 || first_dv < 0) && n < 100) begin
      @(negedge clk_i);
      if (first_dv < 0 && tl_o.d_valid) first_dv = cyc;
      if (tl_i.a_valid && tl_o.a_ready) begin
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      tick();
      n++;
      if (hs_cnt - start >= 16) tl_i.a_valid = 1'b0;
      else get_fields(32'($urandom_range(0, 63) * 4), 8'(hs_cnt - start));
    end
    tl_i.a_valid = 1'b0;
    check("t5_hs", hs_cnt - start, 16);
    check("t5_span", last_hs - first_hs, 15);
    check("t5_latency", first_dv - first_hs, 2);
    wait_drain();

    // Reset with two responses queued and one in stage 1
    tl_i.d_ready = 1'b0;
    start = hs_cnt;
    get_fields(32'h40, 8'd0);
    tl_i.a_valid = 1'b1;
    n = 0;
    while (hs_cnt - start < 3 && n < 50) begin
      @(negedge clk_i);
      tick();
      tl_i.a_source = 8'(hs_cnt - start);
      n++;
    end
    rst_ni = 1'b0;
    tl_i.a_valid = 1'b0;
    @(negedge clk_i);
    check("t6_d_valid", tl_o.d_valid, 1'b0);
    tick();
    tick();
    rst_ni = 1'b1;
    tl_i.d_ready = 1'b1;
    p0 = pop_cnt;
    send(Get, 32'h40, 2'd2, 4'hF, 32'h0, 8'd9);
    wait_drain();
    check("t6_pops", pop_cnt - p0, 1);

    // Randomized traffic with randomized d_ready
    rand_dr = 1;
    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = Get;
        4, 5, 6:    op = PutFullData;
        7, 8:       op = PutPartialData;
        default:    op = 3'($urandom_range(0, 7));
      endcase
      sz   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0)  addr += 32'(1 << (SramAw + 2));
      if ($urandom_range(0, 7) == 0)  addr += 32'($urandom_range(0, 3));
      else if (sz == 2'd0)            addr += 32'($urandom_range(0, 3));
      else if (sz == 2'd1)            addr += 32'($urandom_range(0, 1) * 2);
      mask = 4'($urandom_range(0, 15));
      if (op == PutFullData && $urandom_range(0, 7) != 0)
        mask = full_mask(sz, addr[1:0]);
      send(op, addr, sz, mask, $urandom(), 8'(t));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_dr = 0;
    tl_i.d_ready = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
